// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - FSM encoding, requester IDs and default widths for the unified memory arbiter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/arb_latency_counter.sv
// rtl/arb_latency_counter.sv - 4-bit load/decrement counter with zero flag for the memory wait phase
module arb_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  // Saturates at zero so an extra decrement in the final wait cycle is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - core/loader arbiter for the single-port memory; ARB_ROUND_ROBIN_EN selects round-robin over fixed core priority
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic [DW-1:0] l_rdata,
  output logic          l_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  arb_state_t state;
  logic       lat_we;
  logic       grant_loader;
  logic       cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  assign grant_loader = l_req && (!c_req || (rr_ptr == REQ_LOADER));

  // Every grant hands priority to the other requester, contended or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= REQ_CORE;
    end else if ((state == IDLE) && (c_req || l_req)) begin
      rr_ptr <= ~grant_loader;
    end
  end
`else
  assign grant_loader = l_req && !c_req;
`endif

  arb_latency_counter u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ISSUE),
    .dec      (state == WAIT),
    .load_val (LAT_M1),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      c_ack     <= 1'b0;
      l_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= REQ_CORE;
      lat_we    <= 1'b0;
    end else begin
      c_ack  <= 1'b0;
      l_ack  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            // Strobe is registered here so it is high for exactly the ISSUE cycle.
            owner     <= grant_loader;
            lat_we    <= grant_loader ? l_we : c_we;
            mem_we    <= grant_loader ? l_we : c_we;
            mem_addr  <= grant_loader ? l_addr : c_addr;
            mem_wdata <= grant_loader ? l_wdata : c_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cnt_zero) begin
            if (!lat_we) begin
              if (owner == REQ_LOADER) begin
                l_rdata <= mem_rdata;
              end else begin
                c_rdata <= mem_rdata;
              end
            end
            if (owner == REQ_LOADER) begin
              l_ack <= 1'b1;
            end else begin
              c_ack <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - bench for unified_mem_arbiter at MEM_LAT 2, 1 and 15
module tb_unified_mem_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        c_req [NI], c_we [NI], c_ack [NI];
  logic        l_req [NI], l_we [NI], l_ack [NI];
  logic        mem_en [NI], mem_we [NI], busy [NI], owner [NI];
  logic [31:0] c_addr [NI], c_wdata [NI], c_rdata [NI];
  logic [31:0] l_addr [NI], l_wdata [NI], l_rdata [NI];
  logic [31:0] mem_addr [NI], mem_wdata [NI], mem_rdata [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt [NI];
  int since [NI];
  int dual_ack = 0;
  bit [31:0] rd_addr [NI];
  bit [31:0] mem_store [NI][256];
  bit        mem_wr [NI][256];

  bit [31:0] ref_mem [NI][256];
  bit        ref_wr [NI][256];
  logic [31:0] exp_crd [NI], exp_lrd [NI];
  logic        rr_ptr [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic [31:0] mem_dflt(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] ref_read(input int k, input logic [31:0] a);
    if (ref_wr[k][a[9:2]]) return ref_mem[k][a[9:2]];
    return mem_dflt(a);
  endfunction

  // Memory macro model: data is only valid exactly MEM_LAT cycles after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (mem_en[k]) begin
        en_cnt[k]  <= en_cnt[k] + 1;
        since[k]   <= 1;
        rd_addr[k] <= mem_addr[k];
        if (mem_we[k]) begin
          mem_store[k][mem_addr[k][9:2]] <= mem_wdata[k];
          mem_wr[k][mem_addr[k][9:2]]    <= 1'b1;
        end
      end else if (since[k] < 1000) begin
        since[k] <= since[k] + 1;
      end
      if (c_ack[k] && l_ack[k]) dual_ack <= dual_ack + 1;
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    assign mem_rdata[g] = (since[g] == L)
        ? (mem_wr[g][rd_addr[g][9:2]] ? mem_store[g][rd_addr[g][9:2]] : mem_dflt(rd_addr[g]))
        : (32'hBAD0_0000 | 32'(since[g]));

    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_rdata(c_rdata[g]), .c_ack(c_ack[g]),
      .l_req(l_req[g]), .l_we(l_we[g]), .l_addr(l_addr[g]), .l_wdata(l_wdata[g]),
      .l_rdata(l_rdata[g]), .l_ack(l_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .owner(owner[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int k, input logic who, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (who) begin
      l_req[k] = req; l_we[k] = we; l_addr[k] = a; l_wdata[k] = d;
    end else begin
      c_req[k] = req; c_we[k] = we; c_addr[k] = a; c_wdata[k] = d;
    end
  endtask

  // One isolated transaction; starts and ends with the arbiter idle.
  task automatic run_txn(input string tag, input int k, input logic who, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input bit drop_early);
    int n, en0, en_cyc, ack_cyc, L;
    bit other;
    L = lat_of(k);
    @(negedge clk);
    drive(k, who, 1'b1, we, a, d);
    n = cyc; en0 = en_cnt[k]; en_cyc = -1; ack_cyc = -1; other = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_en[k] && en_cyc < 0) begin
        en_cyc = cyc;
        chk({tag, ".mem_we"}, 32'(mem_we[k]), 32'(we));
        chk({tag, ".mem_addr"}, mem_addr[k], a);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata[k], d);
      end
      if (drop_early && busy[k]) drive(k, who, 1'b0, we, a, d);
      if (who ? c_ack[k] : l_ack[k]) other = 1'b1;
      if (who ? l_ack[k] : c_ack[k]) begin
        ack_cyc = cyc;
        drive(k, who, 1'b0, we, a, d);
        break;
      end
    end
    rr_ptr[k] = ~who;
    if (we) begin
      ref_mem[k][a[9:2]] = d;
      ref_wr[k][a[9:2]] = 1'b1;
    end else if (who) begin
      exp_lrd[k] = ref_read(k, a);
    end else begin
      exp_crd[k] = ref_read(k, a);
    end
    chk({tag, ".en_cycle"}, en_cyc, n + 1);
    chk({tag, ".ack_cycle"}, ack_cyc, n + 2 + L);
    chk({tag, ".en_count"}, en_cnt[k] - en0, 1);
    chk({tag, ".other_ack"}, 32'(other), 0);
    chk({tag, ".owner"}, 32'(owner[k]), 32'(who));
    chk({tag, ".c_rdata"}, c_rdata[k], exp_crd[k]);
    chk({tag, ".l_rdata"}, l_rdata[k], exp_lrd[k]);
  endtask

  // Both requesters raise req in the same idle cycle; each drops on its own ack.
  task automatic contend(input string tag, input int k);
    int n, L, cc, lc, en0;
    logic first;
    logic [31:0] ca, la;
    L = lat_of(k);
`ifdef ARB_ROUND_ROBIN_EN
    first = rr_ptr[k];
`else
    first = 1'b0;
`endif
    ca = 32'($urandom_range(0, 63)) << 2;
    la = 32'($urandom_range(64, 127)) << 2;
    @(negedge clk);
    drive(k, 1'b0, 1'b1, 1'b0, ca, 32'h0);
    drive(k, 1'b1, 1'b1, 1'b0, la, 32'h0);
    n = cyc; cc = -1; lc = -1; en0 = en_cnt[k];
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (c_ack[k]) begin
        cc = cyc; drive(k, 1'b0, 1'b0, 1'b0, ca, 32'h0);
        chk({tag, ".c_rdata"}, c_rdata[k], ref_read(k, ca));
      end
      if (l_ack[k]) begin
        lc = cyc; drive(k, 1'b1, 1'b0, 1'b0, la, 32'h0);
        chk({tag, ".l_rdata"}, l_rdata[k], ref_read(k, la));
      end
      if (cc >= 0 && lc >= 0) break;
    end
    exp_crd[k] = ref_read(k, ca);
    exp_lrd[k] = ref_read(k, la);
    rr_ptr[k] = ~first;
    rr_ptr[k] = first;
    chk({tag, ".c_ack_cycle"}, cc, first ? n + 5 + 2 * L : n + 2 + L);
    chk({tag, ".l_ack_cycle"}, lc, first ? n + 2 + L : n + 5 + 2 * L);
    chk({tag, ".en_count"}, en_cnt[k] - en0, 2);
  endtask

  // Core holds req across acks and changes address each time: back-to-back reads.
  task automatic sweep(input string tag, input int k);
    int n, L, prev, acks, en0;
    logic [31:0] a;
    L = lat_of(k);
    a = 32'($urandom_range(0, 255)) << 2;
    @(negedge clk);
    drive(k, 1'b0, 1'b1, 1'b0, a, 32'h0);
    n = cyc; prev = -1; acks = 0; en0 = en_cnt[k];
    for (int i = 0; i < 200 && acks < 4; i++) begin
      @(negedge clk);
      if (c_ack[k]) begin
        acks++;
        chk({tag, ".rdata"}, c_rdata[k], ref_read(k, a));
        if (prev < 0) chk({tag, ".first_ack"}, cyc, n + 2 + L);
        else chk({tag, ".spacing"}, cyc - prev, L + 3);
        prev = cyc;
        a = 32'($urandom_range(0, 255)) << 2;
        drive(k, 1'b0, (acks < 4), 1'b0, a, 32'h0);
      end
    end
    chk({tag, ".acks"}, acks, 4);
    chk({tag, ".en_count"}, en_cnt[k] - en0, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks;
    logic who, we;
    logic [31:0] a;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(k, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      exp_crd[k] = 32'h0; exp_lrd[k] = 32'h0; rr_ptr[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy[0]), 0);
    chk("reset.mem_en", 32'(mem_en[0]), 0);
    chk("reset.acks", {30'd0, c_ack[0], l_ack[0]}, 0);
    chk("reset.c_rdata", c_rdata[0], 0);
    chk("reset.mem_addr", mem_addr[0], 0);
    chk("reset.owner", 32'(owner[0]), 0);
    rst = 1'b0;

    run_txn("core_read", 0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    run_txn("ldr_write", 0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    run_txn("core_readback", 0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    run_txn("drop_early", 0, 1'b0, 1'b0, 32'h44, 32'h0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      who = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 15)) << 2;
      run_txn($sformatf("rand%0d", i), 0, who, we, a, $urandom, 1'b0);
    end

    // Reset mid-transaction: abort during WAIT, then a fresh request must work.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    n = cyc;
    repeat (2) @(negedge clk);
    chk("rst_wait.busy_before", 32'(busy[0]), 1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk("rst_wait.busy", 32'(busy[0]), 0);
    chk("rst_wait.mem_en", 32'(mem_en[0]), 0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_ack[0] || l_ack[0]) acks++;
    end
    chk("rst_wait.no_ack", acks, 0);
    exp_crd[0] = 32'h0; exp_lrd[0] = 32'h0; rr_ptr[0] = 1'b0;
    chk("rst_wait.c_rdata", c_rdata[0], 0);
    run_txn("after_rst", 0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Contention from a fresh reset: pointer at core, then a lone core grant.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_crd[0] = 32'h0; exp_lrd[0] = 32'h0; rr_ptr[0] = 1'b0;
    contend("contend1", 0);
    run_txn("between", 0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
    contend("contend2", 0);

    sweep("lat1", 1);
    sweep("lat15", 2);

    chk("dual_ack", dual_ack, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
